// File: rtl/bottle_print_sched_pkg.sv
// Shared types and defaults for the bottle-print job scheduler.
package bottle_print_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_e;

    localparam int unsigned DEF_GAP_CYC = 16;
    localparam int unsigned DEF_CNT_W   = 4;

    function automatic int unsigned road_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bottle_print_sched_rr_arb.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping at N.
module bp_rr_arb #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                gnt_o = W'(idx);
            end
        end
    end

endmodule

// File: rtl/bottle_print_sched.sv
// Per-road pending counters, round-robin grant and job sequencing for the
// shared bottle-print engine. All outputs are registered from next-state.
module bottle_print_sched
    import bottle_print_pkg::*;
#(
    parameter int unsigned N_ROAD  = 8,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic              clk_100,
    input  logic              RST,
    input  logic [N_ROAD-1:0] trig,
    input  logic [N_ROAD-1:0] road_en,
    input  logic [7:0]        cycle_cfg,
    input  logic              clr_req,
    input  logic [15:0]       timeout_cfg,
    input  logic              print_done,
    output logic              valid_edge_f1,
    output logic [7:0]        b_p_road_num,
    output logic [7:0]        b_p_cycle_num,
    output logic              b_p_clr,
    output logic              dianyan_en,
    output logic              busy,
    output logic [N_ROAD-1:0] ovf,
    output logic              tmo_err
);

    localparam int unsigned ROAD_W = road_w(N_ROAD);
    localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);

    state_e              state_q, state_d;
    logic [ROAD_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]    cnt_q [N_ROAD];
    logic [CNT_W-1:0]    cnt_d [N_ROAD];
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;
    logic                valid_q, valid_d;
    logic [7:0]          road_q, road_d;
    logic [7:0]          cyc_q, cyc_d;
    logic                clr_q, clr_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic [N_ROAD-1:0]   ovf_q, ovf_d;
    logic                tmo_err_q, tmo_err_d;

    logic [N_ROAD-1:0]   req;
    logic [N_ROAD-1:0]   dec;
    logic [ROAD_W-1:0]   arb_gnt;
    logic                arb_any;

    always_comb begin
        for (int unsigned i = 0; i < N_ROAD; i++) begin
            req[i] = road_en[i] && (cnt_q[i] != '0);
        end
    end

    bp_rr_arb #(
        .N (N_ROAD),
        .W (ROAD_W)
    ) u_arb (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .any_o  (arb_any)
    );

    always_comb begin
        logic inc;
        inc       = 1'b0;
        state_d   = state_q;
        last_d    = last_q;
        gap_d     = gap_q;
        tmo_cnt_d = tmo_cnt_q;
        road_d    = road_q;
        cyc_d     = cyc_q;
        ovf_d     = ovf_q;
        tmo_err_d = tmo_err_q;
        clr_d     = clr_req;
        dec       = '0;

        unique case (state_q)
            S_IDLE: begin
                // A flush in IDLE suppresses the grant for that cycle.
                if (!clr_req && arb_any) begin
                    state_d      = S_ISSUE;
                    road_d       = 8'(arb_gnt);
                    cyc_d        = (cycle_cfg == 8'd0) ? 8'd1 : cycle_cfg;
                    dec[arb_gnt] = 1'b1;
                end
            end
            S_ISSUE: begin
                gap_d     = '0;
                tmo_cnt_d = '0;
                state_d   = clr_req ? S_GAP : S_WAIT;
            end
            S_WAIT: begin
                gap_d = '0;
                if (clr_req) begin
                    state_d = S_GAP;
                end else if (print_done) begin
                    state_d = S_GAP;
                    last_d  = road_q[ROAD_W-1:0];
                end else if (timeout_cfg != 16'd0 &&
                             tmo_cnt_q == timeout_cfg - 16'd1) begin
                    state_d   = S_GAP;
                    last_d    = road_q[ROAD_W-1:0];
                    tmo_err_d = 1'b1;
                    clr_d     = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int unsigned i = 0; i < N_ROAD; i++) begin
            cnt_d[i] = cnt_q[i];
            inc      = trig[i] && road_en[i];
            if (clr_req) begin
                cnt_d[i] = '0;
            end else if (inc && !dec[i]) begin
                if (cnt_q[i] == '1) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (!inc && dec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        valid_d = (state_d == S_ISSUE);
        en_d    = (state_d == S_ISSUE) || (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_100) begin
        if (RST) begin
            state_q   <= S_IDLE;
            last_q    <= ROAD_W'(N_ROAD - 1);
            gap_q     <= '0;
            tmo_cnt_q <= '0;
            valid_q   <= 1'b0;
            road_q    <= '0;
            cyc_q     <= '0;
            clr_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= '0;
            tmo_err_q <= 1'b0;
            for (int unsigned i = 0; i < N_ROAD; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            tmo_cnt_q <= tmo_cnt_d;
            valid_q   <= valid_d;
            road_q    <= road_d;
            cyc_q     <= cyc_d;
            clr_q     <= clr_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            tmo_err_q <= tmo_err_d;
            for (int unsigned i = 0; i < N_ROAD; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign valid_edge_f1 = valid_q;
    assign b_p_road_num  = road_q;
    assign b_p_cycle_num = cyc_q;
    assign b_p_clr       = clr_q;
    assign dianyan_en    = en_q;
    assign busy          = busy_q;
    assign ovf           = ovf_q;
    assign tmo_err       = tmo_err_q;

endmodule

// File: tb/tb_bottle_print_sched.sv
// Directed bench for bottle_print_sched: vector table for single jobs plus
// hand sequences for fairness, overflow, timeout, flush, mask and reset.
module tb_bottle_print_sched;

    localparam int GAP_CYC = 16;

    logic        clk_100 = 1'b0;
    logic        RST;
    logic [7:0]  trig;
    logic [7:0]  road_en;
    logic [7:0]  cycle_cfg;
    logic        clr_req;
    logic [15:0] timeout_cfg;
    logic        print_done;
    logic        valid_edge_f1;
    logic [7:0]  b_p_road_num;
    logic [7:0]  b_p_cycle_num;
    logic        b_p_clr;
    logic        dianyan_en;
    logic        busy;
    logic [7:0]  ovf;
    logic        tmo_err;

    int n_tests = 0;
    int n_fail  = 0;

    bottle_print_sched #(
        .N_ROAD  (8),
        .CNT_W   (4),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk_100       (clk_100),
        .RST           (RST),
        .trig          (trig),
        .road_en       (road_en),
        .cycle_cfg     (cycle_cfg),
        .clr_req       (clr_req),
        .timeout_cfg   (timeout_cfg),
        .print_done    (print_done),
        .valid_edge_f1 (valid_edge_f1),
        .b_p_road_num  (b_p_road_num),
        .b_p_cycle_num (b_p_cycle_num),
        .b_p_clr       (b_p_clr),
        .dianyan_en    (dianyan_en),
        .busy          (busy),
        .ovf           (ovf),
        .tmo_err       (tmo_err)
    );

    always #5 clk_100 = ~clk_100;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    typedef struct {
        int         road;
        logic [7:0] cfg;
        logic [7:0] exp_cyc;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (valid_edge_f1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (!busy) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic finish_job();
        int n;
        print_done = 1'b1;
        tick();
        print_done = 1'b0;
        wait_idle(40, n);
        chk("job_drain", n, GAP_CYC);
    endtask

    initial begin
        int n;
        int jobs;
        int bad;
        int order[4];

        vecs[0] = '{road: 3, cfg: 8'd0,   exp_cyc: 8'd1};
        vecs[1] = '{road: 6, cfg: 8'd5,   exp_cyc: 8'd5};
        vecs[2] = '{road: 0, cfg: 8'd255, exp_cyc: 8'd255};
        vecs[3] = '{road: 7, cfg: 8'd1,   exp_cyc: 8'd1};
        order   = '{0, 2, 5, 0};

        RST = 1'b1; trig = '0; road_en = 8'hFF; cycle_cfg = '0;
        clr_req = 1'b0; timeout_cfg = '0; print_done = 1'b0;
        tick(); tick();
        chk("rst_valid", valid_edge_f1, 0);
        chk("rst_road",  b_p_road_num, 0);
        chk("rst_cyc",   b_p_cycle_num, 0);
        chk("rst_clr",   b_p_clr, 0);
        chk("rst_en",    dianyan_en, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ovf",   ovf, 0);
        chk("rst_tmo",   tmo_err, 0);
        RST = 1'b0;
        tick();

        // print_done outside WAIT is ignored
        print_done = 1'b1; tick(); print_done = 1'b0;
        chk("done_idle_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            cycle_cfg = vecs[v].cfg;
            trig = 8'd1 << vecs[v].road;
            tick();
            trig = '0;
            chk("tbl_pre_valid", valid_edge_f1, 0);
            tick();
            chk("tbl_valid", valid_edge_f1, 1);
            chk("tbl_road",  b_p_road_num, vecs[v].road);
            chk("tbl_cyc",   b_p_cycle_num, vecs[v].exp_cyc);
            chk("tbl_en",    dianyan_en, 1);
            chk("tbl_busy",  busy, 1);
            cycle_cfg = 8'd77;
            tick();
            chk("tbl_valid_1cyc", valid_edge_f1, 0);
            chk("tbl_en_wait", dianyan_en, 1);
            tick(); tick();
            chk("tbl_cyc_hold", b_p_cycle_num, vecs[v].exp_cyc);
            print_done = 1'b1;
            tick();
            print_done = 1'b0;
            chk("tbl_en_done", dianyan_en, 0);
            chk("tbl_busy_gap", busy, 1);
            wait_idle(40, n);
            chk("tbl_gap_len", n, GAP_CYC);
        end

        // Fairness: last = 7, so order is 0,2,5 then the re-queued 0
        cycle_cfg = 8'd2;
        trig = 8'b0010_0101; tick();
        chk("fair_pre_valid", valid_edge_f1, 0);
        trig = 8'b0000_0001; tick();
        trig = '0;
        chk("fair_first_valid", valid_edge_f1, 1);
        for (int j = 0; j < 4; j++) begin
            chk("fair_road", b_p_road_num, order[j]);
            tick(); tick(); tick();
            print_done = 1'b1; tick(); print_done = 1'b0;
            wait_valid(60, n);
            if (j < 3) chk("fair_gap", n, GAP_CYC + 1);
            else       chk("fair_no_extra", n, -1);
        end

        // Overflow: one job stuck in WAIT while road 1 is flooded
        trig = 8'b0000_0010; tick(); trig = '0;
        tick();
        chk("ovf_first_valid", valid_edge_f1, 1);
        chk("ovf_first_road", b_p_road_num, 1);
        tick();
        trig = 8'b0000_0010;
        for (int i = 0; i < 15; i++) tick();
        trig = '0;
        chk("ovf_not_yet", ovf, 0);
        trig = 8'b0000_0010; tick(); trig = '0;
        chk("ovf_set", ovf, 8'b0000_0010);
        jobs = 0;
        bad  = 0;
        for (int j = 0; j < 20; j++) begin
            print_done = 1'b1; tick(); print_done = 1'b0;
            wait_valid(40, n);
            if (n < 0) break;
            jobs++;
            if (b_p_road_num != 8'd1) bad++;
            tick();
        end
        chk("ovf_jobs", jobs, 15);
        chk("ovf_all_road1", bad, 0);
        chk("ovf_sticky", ovf, 8'b0000_0010);

        // Timeout: roads 2 and 6 pending, road 2 never completes
        timeout_cfg = 16'd100;
        trig = 8'b0100_0100; tick(); trig = '0;
        tick();
        chk("tmo_valid", valid_edge_f1, 1);
        chk("tmo_road", b_p_road_num, 2);
        tick();
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (b_p_clr) begin
                n = i;
                break;
            end
        end
        chk("tmo_latency", n, 100);
        chk("tmo_err_set", tmo_err, 1);
        chk("tmo_en_low", dianyan_en, 0);
        tick();
        chk("tmo_clr_pulse", b_p_clr, 0);
        wait_valid(60, n);
        chk("tmo_next_gap", n + 1, GAP_CYC + 1);
        chk("tmo_next_road", b_p_road_num, 6);
        timeout_cfg = '0;
        tick();
        finish_job();
        chk("tmo_err_sticky", tmo_err, 1);

        // Flush mid-job: road 7 granted, 1/3/5 left pending
        trig = 8'b1010_1010; tick(); trig = '0;
        tick();
        chk("fl_valid", valid_edge_f1, 1);
        chk("fl_road", b_p_road_num, 7);
        tick(); tick();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        chk("fl_clr", b_p_clr, 1);
        chk("fl_en", dianyan_en, 0);
        chk("fl_busy", busy, 1);
        tick();
        chk("fl_clr_1cyc", b_p_clr, 0);
        wait_valid(60, n);
        chk("fl_no_valid", n, -1);
        chk("fl_idle", busy, 0);
        trig = 8'b0000_0001; clr_req = 1'b1; tick();
        trig = '0; clr_req = 1'b0;
        chk("fl_idle_clr", b_p_clr, 1);
        wait_valid(20, n);
        chk("fl_trig_overridden", n, -1);

        // Masking
        road_en = 8'hEF;
        trig = 8'h10; tick(); trig = '0;
        wait_valid(20, n);
        chk("mask_no_grant", n, -1);
        road_en = 8'hFF;
        wait_valid(20, n);
        chk("mask_not_queued", n, -1);
        trig = 8'h08; tick(); trig = '0;
        road_en = 8'hF7;
        wait_valid(20, n);
        chk("mask_held", n, -1);
        road_en = 8'hFF;
        wait_valid(5, n);
        chk("mask_retained_lat", n, 1);
        chk("mask_retained_road", b_p_road_num, 3);
        tick();
        finish_job();

        // Reset during ISSUE
        cycle_cfg = 8'd9;
        trig = 8'h04; tick(); trig = '0;
        tick();
        chk("rst_mid_valid", valid_edge_f1, 1);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("rstm_valid", valid_edge_f1, 0);
        chk("rstm_road",  b_p_road_num, 0);
        chk("rstm_cyc",   b_p_cycle_num, 0);
        chk("rstm_clr",   b_p_clr, 0);
        chk("rstm_en",    dianyan_en, 0);
        chk("rstm_busy",  busy, 0);
        chk("rstm_ovf",   ovf, 0);
        chk("rstm_tmo",   tmo_err, 0);
        trig = 8'h81; tick(); trig = '0;
        tick();
        chk("rstm_regrant", valid_edge_f1, 1);
        chk("rstm_last_reset", b_p_road_num, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
